// File: rtl/vend_timeout_timer.sv
// Timeout timer for the vending controller: decodes start_timer, loads a
// window and counts it down in whole seconds, pulsing timeout_flag on expiry.
module vend_timeout_timer #(
   parameter int unsigned TICKS_PER_SEC = 50_000_000,
   parameter int unsigned WAIT_SEC      = 30,
   parameter int unsigned SELECT_SEC    = 30,
   parameter int unsigned CHANGE_SEC    = 5,
   parameter int unsigned SEC_W         = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       start_timer,
   output logic             timeout_flag,
   output logic             timer_active,
   output logic [1:0]       mode_out,
   output logic [SEC_W-1:0] sec_remaining
);

   localparam int unsigned PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      RUN_WAIT = 2'b01,
      RUN_SEL  = 2'b10,
      RUN_CHG  = 2'b11
   } state_t;

   state_t           state_q, state_d;
   logic [SEC_W-1:0] sec_q, sec_d;
   logic [PW-1:0]    presc_q, presc_d;
   logic [1:0]       prev_q, prev_d;
   logic             flag_q, flag_d;

   logic             load;
   logic [SEC_W-1:0] window;

   // Coin code reloads on every cycle; select/change only on a code change.
   always_comb begin
      load = (start_timer == 2'b01) ||
             (start_timer[1] && (start_timer != prev_q));
      unique case (start_timer)
         2'b01:   window = SEC_W'(WAIT_SEC);
         2'b10:   window = SEC_W'(SELECT_SEC);
         2'b11:   window = SEC_W'(CHANGE_SEC);
         default: window = '0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      sec_d   = sec_q;
      presc_d = presc_q;
      prev_d  = start_timer;
      flag_d  = 1'b0;
      if (load) begin
         state_d = state_t'(start_timer);
         sec_d   = window;
         presc_d = '0;
      end else if (start_timer == 2'b00 &&
                   (state_q == RUN_SEL || state_q == RUN_CHG)) begin
         state_d = IDLE;
         sec_d   = '0;
         presc_d = '0;
      end else if (state_q != IDLE) begin
         if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            if (sec_q == SEC_W'(1)) begin
               state_d = IDLE;
               sec_d   = '0;
               flag_d  = 1'b1;
            end else begin
               sec_d = sec_q - SEC_W'(1);
            end
         end else begin
            presc_d = presc_q + PW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sec_q   <= '0;
         presc_q <= '0;
         prev_q  <= 2'b00;
         flag_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sec_q   <= sec_d;
         presc_q <= presc_d;
         prev_q  <= prev_d;
         flag_q  <= flag_d;
      end
   end

   assign timeout_flag  = flag_q;
   assign timer_active  = (state_q != IDLE);
   assign mode_out      = state_q;
   assign sec_remaining = sec_q;

endmodule

// File: tb/tb_vend_timeout_timer.sv
// Table-driven bench for vend_timeout_timer with a scoreboard queue of
// expected outputs, one record per clock cycle.
module tb_vend_timeout_timer;

   localparam int TPS = 4;
   localparam int WS  = 3;
   localparam int SS  = 3;
   localparam int CS  = 2;
   localparam int SW  = 6;

   logic          clk;
   logic          rst;
   logic [1:0]    start_timer;
   logic          timeout_flag;
   logic          timer_active;
   logic [1:0]    mode_out;
   logic [SW-1:0] sec_remaining;

   vend_timeout_timer #(
      .TICKS_PER_SEC(TPS),
      .WAIT_SEC     (WS),
      .SELECT_SEC   (SS),
      .CHANGE_SEC   (CS),
      .SEC_W        (SW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start_timer  (start_timer),
      .timeout_flag (timeout_flag),
      .timer_active (timer_active),
      .mode_out     (mode_out),
      .sec_remaining(sec_remaining)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic          r;
      logic [1:0]    cmd;
      logic          flag;
      logic          act;
      logic [1:0]    mode;
      logic [SW-1:0] sec;
   } vec_t;

   typedef struct packed {
      logic          flag;
      logic          act;
      logic [1:0]    mode;
      logic [SW-1:0] sec;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   task automatic add(input logic r, input logic [1:0] cmd,
                      input logic f, input logic a,
                      input logic [1:0] m, input int s);
      vec_t v;
      v.r = r; v.cmd = cmd; v.flag = f; v.act = a;
      v.mode = m; v.sec = SW'(s);
      tbl.push_back(v);
   endtask

   // n cycles of a running window: cycle j after the load edge shows
   // secs - j/TPS whole seconds left.
   task automatic hold(input logic [1:0] cmd, input logic [1:0] m,
                       input int secs, input int j0, input int n);
      for (int j = j0; j < j0 + n; j++)
         add(1'b0, cmd, 1'b0, 1'b1, m, secs - j / TPS);
   endtask

   task automatic idle(input logic r, input logic [1:0] cmd, input int n);
      for (int i = 0; i < n; i++)
         add(r, cmd, 1'b0, 1'b0, 2'b00, 0);
   endtask

   initial begin
      // reset with 10 held, then a single load on release and full expiry
      idle(1'b1, 2'b10, 2);
      hold(2'b10, 2'b10, SS, 0, SS * TPS);
      add(1'b0, 2'b10, 1'b1, 1'b0, 2'b00, 0);
      idle(1'b0, 2'b10, 40);
      // two coin pulses five cycles apart; expiry tracks the second
      idle(1'b0, 2'b00, 1);
      add(1'b0, 2'b01, 1'b0, 1'b1, 2'b01, WS);
      hold(2'b00, 2'b01, WS, 1, 4);
      add(1'b0, 2'b01, 1'b0, 1'b1, 2'b01, WS);
      hold(2'b00, 2'b01, WS, 1, WS * TPS - 1);
      add(1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 0);
      idle(1'b0, 2'b00, 1);
      // change window stopped by 00
      hold(2'b11, 2'b11, CS, 0, 3);
      idle(1'b0, 2'b00, 12);
      // select window switched to change window mid-count
      hold(2'b10, 2'b10, SS, 0, 6);
      hold(2'b11, 2'b11, CS, 0, CS * TPS);
      add(1'b0, 2'b11, 1'b1, 1'b0, 2'b00, 0);
      idle(1'b0, 2'b11, 3);
      // reset mid-count with 00, stays quiet afterwards
      hold(2'b10, 2'b10, SS, 0, 7);
      idle(1'b1, 2'b00, 1);
      idle(1'b0, 2'b00, 20);
      // coin reload on the very cycle of expiry suppresses the flag
      add(1'b0, 2'b01, 1'b0, 1'b1, 2'b01, WS);
      hold(2'b00, 2'b01, WS, 1, WS * TPS - 1);
      add(1'b0, 2'b01, 1'b0, 1'b1, 2'b01, WS);
      hold(2'b00, 2'b01, WS, 1, WS * TPS - 1);
      add(1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 0);
      idle(1'b0, 2'b00, 3);

      rst = 1'b1;
      start_timer = 2'b00;
      foreach (tbl[i]) begin
         exp_t e, got;
         @(negedge clk);
         rst = tbl[i].r;
         start_timer = tbl[i].cmd;
         sb.push_back(exp_t'{tbl[i].flag, tbl[i].act,
                             tbl[i].mode, tbl[i].sec});
         @(posedge clk);
         #1;
         got = exp_t'{timeout_flag, timer_active, mode_out, sec_remaining};
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL row%0d scoreboard empty", i);
         end else begin
            e = sb.pop_front();
            if (got !== e) begin
               errors++;
               $display("FAIL row%0d flag/act/mode/sec got %b/%b/%b/%0d want %b/%b/%b/%0d",
                        i, got.flag, got.act, got.mode, got.sec,
                        e.flag, e.act, e.mode, e.sec);
            end
         end
         if (timeout_flag && timer_active) begin
            errors++;
            $display("FAIL row%0d flag_with_active got 1/1 want not both", i);
         end
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
